// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and width helpers for the animated sprite source.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int unsigned CD_DEF = 12;

    typedef logic [CD_DEF-1:0] color_t;
    typedef logic [10:0]       coord_t;

    localparam color_t KEY_COLOR_DEF = '0;

    // A single-frame sprite still exposes a 1-bit frame counter.
    function automatic int unsigned frame_bits(input int unsigned frames);
        return (frames > 1) ? $clog2(frames) : 1;
    endfunction

    function automatic int unsigned ram_addr_bits(input int unsigned frames,
                                                  input int unsigned h_size,
                                                  input int unsigned v_size);
        return $clog2(frames * h_size * v_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_anim_src_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_src_if
// Description : Scan, RAM/palette load, animation control and pixel outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_anim_src_if #(
    parameter int unsigned CD       = 12,
    parameter int unsigned H_SIZE   = 32,
    parameter int unsigned V_SIZE   = 32,
    parameter int unsigned FRAMES   = 4,
    parameter int unsigned PLT_BITS = 2
);
    import sprite_pkg::*;

    localparam int unsigned ADDR_W = ram_addr_bits(FRAMES, H_SIZE, V_SIZE);
    localparam int unsigned FRM_W  = frame_bits(FRAMES);

    coord_t                i_x;
    coord_t                i_y;
    coord_t                i_x0;
    coord_t                i_y0;
    logic                  i_we;
    logic [ADDR_W-1:0]     i_addr_w;
    logic [PLT_BITS-1:0]   i_pixel_in;
    logic                  i_plt_we;
    logic [PLT_BITS-1:0]   i_plt_addr;
    logic [CD-1:0]         i_plt_data;
    logic                  i_frame_tick;
    logic                  i_anim_en;
    logic [7:0]            i_anim_div;
    logic                  i_hflip;
    logic [CD-1:0]         o_sprite_rgb;
    logic                  o_sprite_hit;
    logic [FRM_W-1:0]      o_cur_frame;

    modport master (
        output i_x, i_y, i_x0, i_y0, i_we, i_addr_w, i_pixel_in,
               i_plt_we, i_plt_addr, i_plt_data, i_frame_tick,
               i_anim_en, i_anim_div, i_hflip,
        input  o_sprite_rgb, o_sprite_hit, o_cur_frame
    );

    modport slave (
        input  i_x, i_y, i_x0, i_y0, i_we, i_addr_w, i_pixel_in,
               i_plt_we, i_plt_addr, i_plt_data, i_frame_tick,
               i_anim_en, i_anim_div, i_hflip,
        output o_sprite_rgb, o_sprite_hit, o_cur_frame
    );

endinterface
`default_nettype wire

// File: rtl/sprite_ram.sv
`default_nettype none
// ============================================================================
// Module      : sprite_ram
// Description : Simple dual-port RAM, registered read, old data on collision.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_ram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_addr_w,
    input  wire logic [DATA_WIDTH-1:0] i_data_w,
    input  wire logic [ADDR_WIDTH-1:0] i_addr_r,
    output      logic [DATA_WIDTH-1:0] o_data_r
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_data_r;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr_w] <= i_data_w;
        end
        r_data_r <= r_mem[i_addr_r];
    end

    assign o_data_r = r_data_r;

endmodule
`default_nettype wire

// File: rtl/sprite_anim_src.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_src
// Description : Animated palette-indexed sprite source, 2-cycle latency.
//               Optional SPRITE_HFLIP_EN enables horizontal mirroring.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_anim_src
    import sprite_pkg::*;
#(
    parameter int unsigned   CD        = 12,
    parameter int unsigned   H_SIZE    = 32,
    parameter int unsigned   V_SIZE    = 32,
    parameter int unsigned   FRAMES    = 4,
    parameter int unsigned   PLT_BITS  = 2,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sprite_anim_src_if.slave bus
);

    localparam int unsigned HB     = $clog2(H_SIZE);
    localparam int unsigned VB     = $clog2(V_SIZE);
    localparam int unsigned FB     = frame_bits(FRAMES);
    localparam int unsigned ADDR_W = ram_addr_bits(FRAMES, H_SIZE, V_SIZE);
    localparam int unsigned NPLT   = 2**PLT_BITS;
    localparam logic [FB-1:0] c_frame_one = FB'(1);

    logic [11:0]         w_xr;
    logic [11:0]         w_yr;
    logic                w_in_region;
    logic [HB-1:0]       w_col;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [PLT_BITS-1:0] w_code;
    logic                w_opaque;
    logic [7:0]          w_div_eff;
    logic [8:0]          w_tick_next;

    logic [FB-1:0]       r_frame;
    logic [7:0]          r_tick_cnt;
    logic                r_in_region;
    logic [CD-1:0]       r_rgb;
    logic                r_hit;
    logic [CD-1:0]       r_palette [NPLT];

    // Zero-extend to 12 bits so the subtraction yields a signed offset.
    assign w_xr = {1'b0, bus.i_x} - {1'b0, bus.i_x0};
    assign w_yr = {1'b0, bus.i_y} - {1'b0, bus.i_y0};

    assign w_in_region = (w_xr[11] == 1'b0) && (w_xr[10:0] < 11'(H_SIZE)) &&
                         (w_yr[11] == 1'b0) && (w_yr[10:0] < 11'(V_SIZE));

`ifdef SPRITE_HFLIP_EN
    // H_SIZE is a power of two, so H_SIZE-1-col is a bitwise inversion.
    assign w_col = bus.i_hflip ? ~w_xr[HB-1:0] : w_xr[HB-1:0];
`else
    logic w_unused_hflip;
    assign w_unused_hflip = bus.i_hflip;
    assign w_col          = w_xr[HB-1:0];
`endif

    generate
        if (FRAMES > 1) begin : g_addr_frames
            assign w_rd_addr = {r_frame, w_yr[VB-1:0], w_col};
        end else begin : g_addr_single
            assign w_rd_addr = {w_yr[VB-1:0], w_col};
        end
    endgenerate

    sprite_ram #(
        .ADDR_WIDTH (ADDR_W),
        .DATA_WIDTH (PLT_BITS)
    ) u_ram (
        .clk      (clk),
        .i_we     (bus.i_we),
        .i_addr_w (bus.i_addr_w),
        .i_data_w (bus.i_pixel_in),
        .i_addr_r (w_rd_addr),
        .o_data_r (w_code)
    );

    assign w_opaque = r_in_region && (w_code != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPLT; i++) begin
                r_palette[i] <= '0;
            end
        end else if (bus.i_plt_we) begin
            r_palette[bus.i_plt_addr] <= bus.i_plt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_region <= 1'b0;
            r_rgb       <= KEY_COLOR;
            r_hit       <= 1'b0;
        end else begin
            r_in_region <= w_in_region;
            r_rgb       <= w_opaque ? r_palette[w_code] : KEY_COLOR;
            r_hit       <= w_opaque;
        end
    end

    assign w_div_eff   = (bus.i_anim_div == 8'd0) ? 8'd1 : bus.i_anim_div;
    assign w_tick_next = {1'b0, r_tick_cnt} + 9'd1;

    // Frame only moves on frame_tick, i.e. during vertical blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= 8'd0;
            r_frame    <= '0;
        end else if (!bus.i_anim_en) begin
            r_tick_cnt <= 8'd0;
        end else if (bus.i_frame_tick) begin
            if (w_tick_next >= {1'b0, w_div_eff}) begin
                r_tick_cnt <= 8'd0;
                if (FRAMES > 1) begin
                    r_frame <= r_frame + c_frame_one;
                end
            end else begin
                r_tick_cnt <= w_tick_next[7:0];
            end
        end
    end

    assign bus.o_sprite_rgb = r_rgb;
    assign bus.o_sprite_hit = r_hit;
    assign bus.o_cur_frame  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_sprite_anim_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_anim_src
// Description : Self-checking bench for sprite_anim_src with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_anim_src;

    localparam int    H    = 32;
    localparam int    V    = 32;
    localparam int    NF   = 4;
    localparam int    NPIX = NF * H * V;
    localparam logic [11:0] KEY = 12'h000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_anim_src_if #(.CD(12), .H_SIZE(H), .V_SIZE(V), .FRAMES(NF), .PLT_BITS(2)) bus ();

    sprite_anim_src #(
        .CD(12), .H_SIZE(H), .V_SIZE(V), .FRAMES(NF), .PLT_BITS(2), .KEY_COLOR(KEY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  m_mem [NPIX];
    logic [11:0] m_pal [4];
    int          m_frame = 0;
    int          m_cnt   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected pixel straight from the geometric rules and the model's memory.
    function automatic void exp_pix(input int x, input int y, input int x0, input int y0,
                                    input bit hf, output logic [11:0] rgb, output logic hit);
        int xr, yr, col;
        logic [1:0] code;
        xr = x - x0;
        yr = y - y0;
        rgb = KEY;
        hit = 1'b0;
        if (xr < 0 || xr >= H || yr < 0 || yr >= V) return;
        col = xr;
`ifdef SPRITE_HFLIP_EN
        if (hf) col = H - 1 - xr;
`endif
        code = m_mem[m_frame * H * V + yr * H + col];
        hit  = (code != 2'd0);
        rgb  = hit ? m_pal[code] : KEY;
    endfunction

    task automatic wr(input int a, input logic [1:0] c);
        bus.i_we = 1'b1; bus.i_addr_w = 12'(a); bus.i_pixel_in = c;
        m_mem[a] = c;
        step();
        bus.i_we = 1'b0;
    endtask

    task automatic pw(input int a, input logic [11:0] d);
        bus.i_plt_we = 1'b1; bus.i_plt_addr = 2'(a); bus.i_plt_data = d;
        step();
        bus.i_plt_we = 1'b0;
        m_pal[a] = d;
    endtask

    task automatic drive(input int x, input int y, input bit hf);
        bus.i_x = 11'(x); bus.i_y = 11'(y); bus.i_hflip = hf;
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input bit hf);
        logic [11:0] e_rgb;
        logic        e_hit;
        drive(x, y, hf);
        exp_pix(x, y, int'(bus.i_x0), int'(bus.i_y0), hf, e_rgb, e_hit);
        step();
        step();
        chk({tag, "_rgb"}, 32'(bus.o_sprite_rgb), 32'(e_rgb));
        chk({tag, "_hit"}, 32'(bus.o_sprite_hit), 32'(e_hit));
    endtask

    // One clock of animation control with the model advanced from the rules.
    task automatic cyc(input string tag, input bit en, input int div, input bit tick);
        int d;
        bus.i_anim_en = en; bus.i_anim_div = 8'(div); bus.i_frame_tick = tick;
        d = (div == 0) ? 1 : div;
        if (!en) m_cnt = 0;
        else if (tick) begin
            m_cnt++;
            if (m_cnt >= d) begin
                m_cnt = 0;
                m_frame = (m_frame + 1) % NF;
            end
        end
        step();
        bus.i_frame_tick = 1'b0;
        chk(tag, 32'(bus.o_cur_frame), 32'(m_frame));
    endtask

    initial begin
        logic [11:0] e_rgb, p_rgb;
        logic        e_hit, p_hit;
        int          x, y;
        bit          hf;

        drive(0, 0, 1'b0);
        bus.i_x0 = 11'd100; bus.i_y0 = 11'd100;
        bus.i_we = 1'b0; bus.i_addr_w = '0; bus.i_pixel_in = '0;
        bus.i_plt_we = 1'b0; bus.i_plt_addr = '0; bus.i_plt_data = '0;
        bus.i_frame_tick = 1'b0; bus.i_anim_en = 1'b0; bus.i_anim_div = 8'd0;
        for (int i = 0; i < 4; i++) m_pal[i] = 12'h000;

        step();
        step();
        chk("reset_rgb",   32'(bus.o_sprite_rgb), 32'(KEY));
        chk("reset_hit",   32'(bus.o_sprite_hit), 32'd0);
        chk("reset_frame", 32'(bus.o_cur_frame),  32'd0);
        rst_n = 1'b1;

        for (int a = 0; a < NPIX; a++) wr(a, 2'($urandom_range(0, 3)));
        wr(0, 2'd1);
        wr(1, 2'd0);
        wr(H, 2'd2);
        wr(H + H - 1, 2'd3);
        pw(0, 12'hFFF);
        pw(1, 12'hF00);
        pw(2, 12'h00F);
        pw(3, 12'($urandom_range(1, 4095)));

        // Latency: nothing at one cycle, the pixel at exactly two.
        drive(100, 100, 1'b0);
        step();
        chk("lat1_hit", 32'(bus.o_sprite_hit), 32'd0);
        step();
        chk("lat2_rgb", 32'(bus.o_sprite_rgb), 32'h0F00);
        chk("lat2_hit", 32'(bus.o_sprite_hit), 32'd1);

        pix_check("left_out",  99, 100, 1'b0);
        pix_check("right_out", 132, 100, 1'b0);
        pix_check("above_out", 100, 99, 1'b0);
        pix_check("below_out", 100, 132, 1'b0);
        pix_check("code0",     101, 100, 1'b0);
        pix_check("last_col",  131, 101, 1'b0);
        pix_check("hflip",     131, 101, 1'b1);

        // Palette write lands in the cycle the pixel reads the palette.
        drive(100, 100, 1'b0);
        step();
        bus.i_plt_we = 1'b1; bus.i_plt_addr = 2'd1; bus.i_plt_data = 12'h0F0;
        step();
        bus.i_plt_we = 1'b0;
        chk("plt_old", 32'(bus.o_sprite_rgb), 32'h0F00);
        m_pal[1] = 12'h0F0;
        step();
        chk("plt_new", 32'(bus.o_sprite_rgb), 32'h00F0);

        for (int t = 0; t < 12; t++) begin
            cyc("div3_tick", 1'b1, 3, 1'b1);
            cyc("div3_idle", 1'b1, 3, 1'b0);
        end
        chk("div3_wrap", 32'(bus.o_cur_frame), 32'd0);
        for (int t = 0; t < 4; t++) cyc("div0_tick", 1'b1, 0, 1'b1);
        for (int t = 0; t < 2; t++) cyc("en_pre", 1'b1, 3, 1'b1);
        for (int t = 0; t < 5; t++) cyc("en_off", 1'b0, 3, 1'b1);
        for (int t = 0; t < 3; t++) cyc("en_re", 1'b1, 3, 1'b1);
        for (int t = 0; t < 3; t++) cyc("div5", 1'b1, 5, 1'b1);
        cyc("div_shrink", 1'b1, 2, 1'b1);

        for (int c = 0; c < 200; c++)
            cyc("rand_anim", ($urandom_range(0, 4) != 0), int'($urandom_range(0, 4)),
                ($urandom_range(0, 2) == 0));
        bus.i_anim_en = 1'b0;

        bus.i_x0 = 11'($urandom_range(0, 1900));
        bus.i_y0 = 11'($urandom_range(0, 1900));
        for (int i = 0; i < 300; i++) begin
            x  = int'(bus.i_x0) + int'($urandom_range(0, 40)) - 4;
            y  = int'(bus.i_y0) + int'($urandom_range(0, 40)) - 4;
            hf = 1'($urandom_range(0, 1));
            drive(x, y, hf);
            exp_pix(x, y, int'(bus.i_x0), int'(bus.i_y0), hf, e_rgb, e_hit);
            step();
            if (i > 0) begin
                chk("rand_rgb", 32'(bus.o_sprite_rgb), 32'(p_rgb));
                chk("rand_hit", 32'(bus.o_sprite_hit), 32'(p_hit));
            end
            p_rgb = e_rgb;
            p_hit = e_hit;
        end
        step();
        chk("rand_last_rgb", 32'(bus.o_sprite_rgb), 32'(p_rgb));
        chk("rand_last_hit", 32'(bus.o_sprite_hit), 32'(p_hit));

        // Asynchronous reset in the middle of an opaque run.
        if (m_frame == 0) cyc("pre_rst", 1'b1, 1, 1'b1);
        bus.i_anim_en = 1'b0;
        bus.i_x0 = 11'd100; bus.i_y0 = 11'd100;
        m_frame = 0;
        for (int f = 0; f < NF; f++) wr(f * H * V, 2'd1);
        for (int t = 0; t < NF; t++) if (bus.o_cur_frame == 2'd0) cyc("pre_rst2", 1'b1, 1, 1'b1);
        bus.i_anim_en = 1'b0;
        drive(100, 100, 1'b0);
        step();
        step();
        chk("pre_rst_hit", 32'(bus.o_sprite_hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rgb",   32'(bus.o_sprite_rgb), 32'(KEY));
        chk("async_rst_hit",   32'(bus.o_sprite_hit), 32'd0);
        chk("async_rst_frame", 32'(bus.o_cur_frame),  32'd0);
        m_frame = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_pal[i] = 12'h000;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_hit1", 32'(bus.o_sprite_hit), 32'd0);
        step();
        chk("post_rst_rgb", 32'(bus.o_sprite_rgb), 32'(m_pal[1]));
        chk("post_rst_hit", 32'(bus.o_sprite_hit), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_anim_src.md
Name: sprite_anim_src

Overview:
Animated, palette-indexed sprite pixel source; next generation of the single-bit cursor source. Stores FRAMES animation frames of H_SIZE x V_SIZE palette codes in a sync-read RAM, maps codes through a writable palette, and advances frames on vertical-sync ticks. Output feeds the layer mux in the video path beside the other sprite sources, with a fixed 2-cycle latency.

Parameters:
CD, 12, colour depth of palette entries and output
H_SIZE, 32, sprite width in pixels; power of two, 8..128
V_SIZE, 32, sprite height in pixels; power of two, 8..128
FRAMES, 4, number of animation frames; power of two, 1..8
PLT_BITS, 2, palette code width; palette holds 2**PLT_BITS entries
KEY_COLOR, 0, chroma-key colour driven when transparent or outside the sprite

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
x, y  in  11 each  current scan coordinate
x0, y0  in  11 each  sprite origin (top-left)
we  in  1  sprite RAM write enable
addr_w  in  ADDR  RAM write address {frame, row, col}; ADDR = log2(FRAMES*H_SIZE*V_SIZE)
pixel_in  in  PLT_BITS  palette code written to RAM
plt_we  in  1  palette write enable
plt_addr  in  PLT_BITS  palette entry index
plt_data  in  CD  palette entry colour
frame_tick  in  1  one-cycle pulse at start of vertical blank
anim_en  in  1  1 = auto-advance frames, 0 = hold frame
anim_div  in  8  frame_ticks per animation step; 0 treated as 1
hflip  in  1  horizontal mirror request (only used with SPRITE_HFLIP_EN)
sprite_rgb  out  CD  pixel colour, 2-cycle latency
sprite_hit  out  1  1 = opaque sprite pixel at this position, aligned with sprite_rgb
cur_frame  out  log2(FRAMES) (min 1)  frame currently displayed

Behaviour:
- Reset (rst_n low, async): sprite_rgb = KEY_COLOR, sprite_hit = 0, cur_frame = 0, tick counter = 0, all palette entries = 0; pipeline registers cleared. Sprite RAM contents are not reset.
- Relative position: xr = x - x0, yr = y - y0, both 12-bit signed; in_region = 0 <= xr < H_SIZE and 0 <= yr < V_SIZE.
- Read address = {cur_frame, yr[log2 V_SIZE-1:0], xr[log2 H_SIZE-1:0]}.
- Stage 1 (cycle n): RAM read issued; in_region registered.
- Stage 2 (cycle n+1): code = RAM dout; opaque = in_region_d1 and code != 0; colour = opaque ? palette[code] : KEY_COLOR; registered to sprite_rgb and sprite_hit at n+2.
- Code 0 is always transparent regardless of palette[0].
- RAM write and read of the same address in the same cycle: read returns old data. Palette write in the same cycle as a palette read: the read returns the old entry; the new value is visible from the next cycle.
- Animation counter: on frame_tick with anim_en = 1, tick_cnt increments; when tick_cnt + 1 >= max(anim_div, 1), tick_cnt is cleared and cur_frame advances, wrapping FRAMES-1 -> 0. Frame changes only on frame_tick, so no mid-frame tearing.
- anim_en = 0: cur_frame holds and tick_cnt is cleared every cycle. Re-enabling starts a full anim_div period.
- FRAMES = 1: cur_frame stays 0.
- anim_div changed mid-count: the new value takes effect immediately. If tick_cnt already >= the new divisor, the frame advances on the next frame_tick.
- Reset asserted mid-line: outputs go to reset values immediately. First valid pixel appears 2 cycles after rst_n deasserts.

Optional Feature:
SPRITE_HFLIP_EN
- Defined: when hflip = 1, the column index used for the read is H_SIZE-1-xr[log2 H_SIZE-1:0]; hflip is sampled in stage 1 together with x.
- Undefined: hflip is ignored (port kept, unused) and the column index is always xr.
- Latency is unchanged in both cases.

Decomposition:
- Package sprite_pkg: colour typedef (logic [CD-1:0] default width 12), coordinate typedef (logic [10:0]), KEY_COLOR default, clog2-based address width helper constants.
- Sub-module sprite_ram: simple dual-port RAM, one write port and one registered read port, read-old-on-collision, parametrised ADDR_WIDTH/DATA_WIDTH.
- Palette registers and animation counter stay in the top module.

Test Plan:
- Load frame 0 with code 1 at (0,0), palette[1]=12'hF00; x0=y0=100; scan x=100,y=100 -> sprite_rgb=12'hF00, sprite_hit=1 exactly 2 cycles later.
- Same setup, x=99 and x=132 (H_SIZE=32) -> sprite_rgb=KEY_COLOR, sprite_hit=0; code 0 pixel inside the region -> KEY_COLOR even with palette[0]=12'hFFF.
- anim_en=1, anim_div=3, FRAMES=4: 12 frame_ticks -> cur_frame 0,0,1,1,1,2,... wrapping to 0 after tick 12; anim_div=0 advances on every tick.
- anim_en drops after 2 ticks, then 5 ticks, then re-enabled -> cur_frame held; next advance occurs 3 ticks after re-enable.
- Palette write plt_addr=1 to 12'h0F0 in the same cycle a pixel reads entry 1 -> that pixel shows old colour, next pixel shows 12'h0F0.
- With SPRITE_HFLIP_EN, hflip=1, code 2 at col 0 -> colour appears at x=x0+31. Assert rst_n low mid-scan -> sprite_rgb=KEY_COLOR and cur_frame=0 asynchronously.
